led_pwm_fader: RTL and testbench

Multi-channel LED PWM generator with per-channel linear fade, clocked directly by FAB_CLK from the MSS01 clock conditioning stage (RC-oscillator-derived, 100 MHz nominal). Firmware or fabric logic writes an 8-bit target brightness per channel. The block produces flicker-free PWM on the LED pins. Duty changes take effect only at PWM period boundaries, either immediately or ramped by one step per period.

---
 rtl/led_pwm_fader.sv | 138 +++++++++++++
 tb/tb_led_pwm_fader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// ---------------------------------------------------------------------------
// led_pwm_fader
//
// Multi-channel LED PWM generator with per-channel linear fade. A prescaler
// divides FAB_CLK down to a PWM tick; an 8-bit PWM counter runs 0..254, so one
// PWM period is 255 ticks. Each channel holds a target duty (tgt), written via
// a simple write strobe, and a current duty (cur) that drives the comparator.
// cur only changes at a period wrap, either jumping to tgt or stepping one
// count toward it, so the LED waveform never glitches mid-period.
//
// Parameters
//   NUM_CH    number of LED channels (1..16)
//   AW        write address width, max(1, clog2(NUM_CH))
//   PRESCALE  FAB_CLK cycles per PWM tick (>= 1)
//
// Ports
//   FAB_CLK     in   fabric clock, all logic on the rising edge
//   RESET       in   synchronous, active-high reset
//   ENABLE      in   1 = run counters and drive LEDs, 0 = counters held at 0, LEDs off
//   FADE        in   1 = ramp cur toward tgt one step per period, 0 = jump
//   WR_EN       in   single-cycle target write strobe
//   WR_ADDR     in   channel index for the write; indices >= NUM_CH are ignored
//   WR_DATA     in   target duty, 0 = off, 255 = fully on
//   LED         out  registered PWM outputs, active-high
//   PERIOD_END  out  one-cycle pulse in the first cycle of each new period
// ---------------------------------------------------------------------------
module led_pwm_fader #(
  parameter int NUM_CH   = 8,
  parameter int AW       = 3,
  parameter int PRESCALE = 100
) (
  input  logic              FAB_CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              FADE,
  input  logic              WR_EN,
  input  logic [AW-1:0]     WR_ADDR,
  input  logic [7:0]        WR_DATA,
  output logic [NUM_CH-1:0] LED,
  output logic              PERIOD_END
);

  // Prescaler width; a PRESCALE of 1 still needs a 1-bit counter that stays 0.
  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX    = PW'(PRESCALE - 1);
  localparam logic [7:0]    PWM_MAX    = 8'd254;
  localparam int            CW         = AW + 1;
  localparam logic [AW:0]   CH_LIMIT   = CW'(NUM_CH);

  logic [PW-1:0] pre_cnt;
  logic [7:0]    pwm_cnt;
  logic [7:0]    tgt [NUM_CH];
  logic [7:0]    cur [NUM_CH];

  logic tick;
  logic wrap;
  logic wr_hit;

  assign tick   = ENABLE && (pre_cnt == PRE_MAX);
  assign wrap   = tick && (pwm_cnt == PWM_MAX);
  // Extra MSB so NUM_CH itself (e.g. 8 with AW=3) is representable.
  assign wr_hit = WR_EN && ({1'b0, WR_ADDR} < CH_LIMIT);

  // -------------------------------------------------------------------------
  // Prescaler and PWM counter. Dropping ENABLE parks both at 0 so that a
  // re-enable always starts a clean, full-length period.
  // -------------------------------------------------------------------------
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (!ENABLE) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= wrap ? 8'd0 : pwm_cnt + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Target registers. Writes are accepted regardless of ENABLE.
  // NOTE: the duty arrays are cleared on reset because the block must come up
  // dark with no stale targets; a plain storage array would normally skip the
  // reset so it can map onto RAM.
  // -------------------------------------------------------------------------
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tgt[i] <= '0;
      end
    end else if (wr_hit) begin
      tgt[WR_ADDR] <= WR_DATA;
    end
  end

  // -------------------------------------------------------------------------
  // Current duty, updated only at the period wrap.
  // NOTE: non-blocking assignments mean tgt here is the value from before this
  // edge, so a write landing on the wrap cycle takes effect one period later.
  // -------------------------------------------------------------------------
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cur[i] <= '0;
      end
    end else if (wrap) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!FADE) begin
          cur[i] <= tgt[i];
        end else if (cur[i] < tgt[i]) begin
          cur[i] <= cur[i] + 8'd1;
        end else if (cur[i] > tgt[i]) begin
          cur[i] <= cur[i] - 8'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs. pwm_cnt never exceeds 254, so cur=255 is solid on and
  // cur=0 is solid off.
  // -------------------------------------------------------------------------
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      LED        <= '0;
      PERIOD_END <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        LED[i] <= ENABLE && (pwm_cnt < cur[i]);
      end
      PERIOD_END <= wrap;
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_fader
//
// Two instances share one stimulus: u_main (NUM_CH=5, PRESCALE=2) covers reset,
// jump mode, duty boundaries, write-on-wrap, bad address and ENABLE drop;
// u_fast (NUM_CH=8, PRESCALE=1) covers fading. Per-period expectations are
// queued by the stimulus; monitors accumulate LED high cycles and period
// length between PERIOD_END pulses and compare against the queue head.
// ---------------------------------------------------------------------------
module tb_led_pwm_fader;

  localparam int M_CH  = 5;
  localparam int M_PRE = 2;
  localparam int M_PER = 255 * M_PRE;
  localparam int F_CH  = 8;
  localparam int F_PRE = 1;
  localparam int F_PER = 255 * F_PRE;
  localparam int LIMIT = 8 * M_PER;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            fade;
  logic            wr_en;
  logic [2:0]      wr_addr;
  logic [7:0]      wr_data;
  logic [M_CH-1:0] led_m;
  logic            pe_m;
  logic [F_CH-1:0] led_f;
  logic            pe_f;

  always #5 clk = ~clk;

  led_pwm_fader #(.NUM_CH(M_CH), .AW(3), .PRESCALE(M_PRE)) u_main (
    .FAB_CLK    (clk),
    .RESET      (rst),
    .ENABLE     (en),
    .FADE       (fade),
    .WR_EN      (wr_en),
    .WR_ADDR    (wr_addr),
    .WR_DATA    (wr_data),
    .LED        (led_m),
    .PERIOD_END (pe_m)
  );

  led_pwm_fader #(.NUM_CH(F_CH), .AW(3), .PRESCALE(F_PRE)) u_fast (
    .FAB_CLK    (clk),
    .RESET      (rst),
    .ENABLE     (en),
    .FADE       (fade),
    .WR_EN      (wr_en),
    .WR_ADDR    (wr_addr),
    .WR_DATA    (wr_data),
    .LED        (led_f),
    .PERIOD_END (pe_f)
  );

  typedef struct packed {
    logic [15:0]                len;
    logic [M_CH-1:0][15:0]      hi;
  } rec_m_t;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] hi3;
  } rec_f_t;

  rec_m_t sb_m[$];
  rec_f_t sb_f[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     exp_cur [M_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive point: just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = 3'(addr);
    wr_data = 8'(data);
    step();
    wr_en   = 1'b0;
  endtask

  // Returns the number of cycles until PERIOD_END is seen, or -1 on timeout.
  task automatic wait_pe(input bit fast, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < LIMIT) begin
      step();
      n++;
      seen = ((fast ? pe_f : pe_m) === 1'b1);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $error("FAIL wait_pe fast=%0d: no PERIOD_END within %0d cycles", fast, LIMIT);
      n = -1;
    end
  endtask

  // Moves past the falling edge on which the monitor closes the current window.
  task automatic past_pe();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input bit fast);
    int n;
    n = 0;
    while (((fast ? sb_f.size() : sb_m.size()) != 0) && n < LIMIT) begin
      step();
      n++;
    end
    if (n >= LIMIT) begin
      n_checks++;
      n_fail++;
      $error("FAIL drain fast=%0d: %0d periods never arrived", fast,
             fast ? sb_f.size() : sb_m.size());
    end
  endtask

  task automatic push_main(input int n);
    rec_m_t r;
    r.len = 16'(M_PER);
    for (int i = 0; i < M_CH; i++) r.hi[i] = 16'(exp_cur[i] * M_PRE);
    repeat (n) sb_m.push_back(r);
  endtask

  task automatic push_fast(input int ticks);
    rec_f_t r;
    r.len = 16'(F_PER);
    r.hi3 = 16'(ticks * F_PRE);
    sb_f.push_back(r);
  endtask

  // Main monitor: the window (previous PERIOD_END, this PERIOD_END] covers
  // exactly one period of LED output, since LED lags the counter by a cycle.
  initial begin : mon_main
    logic [15:0] acc_len;
    logic [15:0] acc_hi [M_CH];
    rec_m_t      e;
    acc_len = '0;
    for (int i = 0; i < M_CH; i++) acc_hi[i] = '0;
    forever begin
      @(negedge clk);
      acc_len = acc_len + 16'd1;
      for (int i = 0; i < M_CH; i++) acc_hi[i] = acc_hi[i] + {15'd0, led_m[i]};
      if (pe_m === 1'b1) begin
        if (sb_m.size() > 0) begin
          e = sb_m.pop_front();
          check("main period length", 32'(acc_len), 32'(e.len));
          for (int i = 0; i < M_CH; i++)
            check($sformatf("main ch%0d high cycles", i), 32'(acc_hi[i]), 32'(e.hi[i]));
        end
        acc_len = '0;
        for (int i = 0; i < M_CH; i++) acc_hi[i] = '0;
      end
    end
  end

  initial begin : mon_fast
    logic [15:0] acc_len;
    logic [15:0] acc_hi3;
    rec_f_t      e;
    acc_len = '0;
    acc_hi3 = '0;
    forever begin
      @(negedge clk);
      acc_len = acc_len + 16'd1;
      acc_hi3 = acc_hi3 + {15'd0, led_f[3]};
      if (pe_f === 1'b1) begin
        if (sb_f.size() > 0) begin
          e = sb_f.pop_front();
          check("fast period length", 32'(acc_len), 32'(e.len));
          check("fast ch3 high ticks", 32'(acc_hi3), 32'(e.hi3));
        end
        acc_len = '0;
        acc_hi3 = '0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rst     = 1'b1;
    en      = 1'b0;
    fade    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) step();
    rst = 1'b0;

    // Random activity so that reset has real state to clear.
    en = 1'b1;
    for (int i = 0; i < F_CH; i++) write(i, int'($urandom_range(255, 1)));
    repeat (600) begin
      if ($urandom_range(3) == 0) write(int'($urandom_range(7)), int'($urandom_range(255, 1)));
      else step();
    end

    // Single-cycle reset.
    rst = 1'b1;
    step();
    check("reset main LED", 32'(led_m), 32'd0);
    check("reset main PERIOD_END", 32'(pe_m), 32'd0);
    check("reset fast LED", 32'(led_f), 32'd0);
    check("reset fast PERIOD_END", 32'(pe_f), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < M_CH; i++) exp_cur[i] = 0;
    wait_pe(1'b0, n);
    check("first period after reset cycles", 32'(n), 32'(M_PER));
    past_pe();
    push_main(3);
    drain(1'b0);

    // Jump mode with half duty and both extremes.
    write(0, 128);
    write(1, 0);
    write(2, 255);
    exp_cur[0] = 128;
    exp_cur[1] = 0;
    exp_cur[2] = 255;
    wait_pe(1'b0, n);
    past_pe();
    push_main(2);
    drain(1'b0);

    // Write landing on the wrap cycle uses the old target for one more period.
    write(0, 10);
    exp_cur[0] = 10;
    wait_pe(1'b0, n);
    repeat (M_PER - 1) step();
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 8'd20;
    step();
    wr_en   = 1'b0;
    check("write coincides with wrap", 32'(pe_m), 32'd1);
    past_pe();
    push_main(1);
    exp_cur[0] = 20;
    push_main(1);
    drain(1'b0);

    // Out-of-range addresses must leave every channel untouched.
    write(5, 8'h55);
    write(6, 8'hAA);
    write(7, 8'h33);
    wait_pe(1'b0, n);
    past_pe();
    push_main(1);
    drain(1'b0);

    // ENABLE drop mid-period; a write while disabled is still accepted.
    wait_pe(1'b0, n);
    repeat (200) step();
    en = 1'b0;
    step();
    check("LED off after enable drop", 32'(led_m), 32'd0);
    check("no PERIOD_END while disabled", 32'(pe_m), 32'd0);
    write(1, 64);
    exp_cur[1] = 64;
    repeat (20) step();
    en = 1'b1;
    wait_pe(1'b0, n);
    check("first period after re-enable cycles", 32'(n), 32'(M_PER));
    past_pe();
    push_main(1);
    drain(1'b0);

    // Fade on the PRESCALE=1 instance: 0 -> 3, then back down to 1.
    fade = 1'b1;
    write(3, 3);
    wait_pe(1'b1, n);
    past_pe();
    push_fast(1);
    push_fast(2);
    push_fast(3);
    push_fast(3);
    drain(1'b1);
    write(3, 1);
    wait_pe(1'b1, n);
    past_pe();
    push_fast(2);
    push_fast(1);
    drain(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
